iram_responder: RTL and testbench

Internal-RAM responder serving the control unit's data-memory requests: 128-byte on-chip RAM holding the four register banks, direct space and stack. Accepts one request at a time over a valid/ready handshake and supports direct, register, register-indirect (@R0/@R1), push and pop accesses. Owns the stack pointer and returns read data and an error flag through a one-cycle response strobe. Sits between the control unit and the ALU/accumulator datapath.

---
 rtl/iram_responder.sv | 246 ++++++++++++++++++++++++
 tb/tb_iram_responder.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iram_responder.sv
// ============================================================================
// iram_responder
//
// Internal-RAM responder for the control unit's data-memory requests. Holds a
// DEPTH-byte on-chip RAM (register banks, direct space, stack), owns the stack
// pointer, and services one request at a time: direct, register, register-
// indirect (@R0/@R1), push and pop. Each request ends with a one-cycle
// response strobe carrying read data and an error flag.
//
// After reset the RAM is swept to zero, one byte per cycle, before the first
// request is accepted.
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   req_valid  in   request present
//   req_ready  out  high only when idle (request accepted on valid & ready)
//   req_mode   in   0=DIR 1=REG 2=RIDIR 3=PUSH 4=POP, 5..7 reserved
//   req_rw     in   1=read 0=write (DIR/REG/RIDIR)
//   req_addr   in   direct address (DIR)
//   req_reg    in   register number Rn (REG); bit 0 picks R0/R1 (RIDIR)
//   req_bank   in   register bank
//   req_wdata  in   write / push data
//   rsp_valid  out  one-cycle response strobe
//   rsp_rdata  out  read / pop data, 0 on writes and errors
//   rsp_err    out  error flag, qualified by rsp_valid
//   sp_out     out  current stack pointer
// ============================================================================
module iram_responder #(
    parameter int          DEPTH    = 128,
    parameter logic [7:0]  SP_RESET = 8'h07
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_mode,
    input  logic        req_rw,
    input  logic [7:0]  req_addr,
    input  logic [2:0]  req_reg,
    input  logic [1:0]  req_bank,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic [7:0]  sp_out
);

    localparam int             AW        = $clog2(DEPTH);
    localparam logic [AW-1:0]  LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [7:0]     TOP_ADDR  = 8'(DEPTH - 1);

    localparam logic [2:0] M_DIR   = 3'd0;
    localparam logic [2:0] M_REG   = 3'd1;
    localparam logic [2:0] M_RIDIR = 3'd2;
    localparam logic [2:0] M_PUSH  = 3'd3;
    localparam logic [2:0] M_POP   = 3'd4;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_PTR,
        S_ACCESS,
        S_RESP
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [7:0]      sp_q, sp_d;
    logic [2:0]      mode_q, mode_d;
    logic            rw_q, rw_d;
    logic [7:0]      addr_q, addr_d;
    logic [2:0]      reg_q, reg_d;
    logic [1:0]      bank_q, bank_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      ptr_q, ptr_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [7:0]      mem_q [DEPTH];
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [7:0]      mem_wdata;

    logic [7:0]      tgt;
    logic [AW-1:0]   tgt_idx;
    logic            acc_err;

    // Effective byte address of the captured request.
    always_comb begin
        unique case (mode_q)
            M_DIR:   tgt = addr_q;
            M_REG:   tgt = {3'b000, bank_q, reg_q};
            M_RIDIR: tgt = ptr_q;
            M_PUSH:  tgt = sp_q + 8'd1;
            M_POP:   tgt = sp_q;
            default: tgt = 8'h00;
        endcase
    end

    assign tgt_idx = tgt[AW-1:0];

    // Error traps are evaluated on the pre-access SP, so SP never wraps and
    // never leaves the RAM range. REG targets are always in range.
    always_comb begin
        unique case (mode_q)
            M_DIR, M_RIDIR: acc_err = (tgt > TOP_ADDR);
            M_REG:          acc_err = 1'b0;
            M_PUSH:         acc_err = (sp_q == TOP_ADDR);
            M_POP:          acc_err = (sp_q == 8'h00);
            default:        acc_err = 1'b1;
        endcase
    end

    // NOTE: every signal driven here gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sp_d      = sp_q;
        mode_d    = mode_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        reg_d     = reg_q;
        bank_d    = bank_q;
        wdata_d   = wdata_q;
        ptr_d     = ptr_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_waddr = tgt_idx;
        mem_wdata = wdata_q;

        unique case (state_q)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = 8'h00;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = S_IDLE;
                end
            end

            S_IDLE: begin
                if (req_valid) begin
                    mode_d  = req_mode;
                    rw_d    = req_rw;
                    addr_d  = req_addr;
                    reg_d   = req_reg;
                    bank_d  = req_bank;
                    wdata_d = req_wdata;
                    state_d = (req_mode == M_RIDIR) ? S_PTR : S_ACCESS;
                end
            end

            // @R0/@R1 live at {bank, 2'b00, r}; only bit 0 of reg picks them.
            S_PTR: begin
                ptr_d   = mem_q[AW'({bank_q, 2'b00, reg_q[0]})];
                state_d = S_ACCESS;
            end

            S_ACCESS: begin
                err_d   = acc_err;
                rdata_d = 8'h00;
                if (!acc_err) begin
                    unique case (mode_q)
                        M_DIR, M_REG, M_RIDIR: begin
                            if (rw_q) begin
                                rdata_d = mem_q[tgt_idx];
                            end else begin
                                mem_we = 1'b1;
                            end
                        end
                        M_PUSH: begin
                            mem_we = 1'b1;
                            sp_d   = sp_q + 8'd1;
                        end
                        M_POP: begin
                            rdata_d = mem_q[tgt_idx];
                            sp_d    = sp_q - 8'd1;
                        end
                        default: ;
                    endcase
                end
                state_d = S_RESP;
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            sp_q    <= SP_RESET;
            mode_q  <= 3'd0;
            rw_q    <= 1'b0;
            addr_q  <= 8'h00;
            reg_q   <= 3'd0;
            bank_q  <= 2'd0;
            wdata_q <= 8'h00;
            ptr_q   <= 8'h00;
            rdata_q <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sp_q    <= sp_d;
            mode_q  <= mode_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            reg_q   <= reg_d;
            bank_q  <= bank_d;
            wdata_q <= wdata_d;
            ptr_q   <= ptr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the RAM array has no reset branch so it maps onto RAM cells; the
    // CLEAR sweep zeroes it instead. Writes are blocked while reset is high.
    always_ff @(posedge clock) begin
        if (!reset && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : 8'h00;
    assign rsp_err   = rsp_valid & err_q;
    assign sp_out    = sp_q;

endmodule

// File: tb/tb_iram_responder.sv
// ============================================================================
// tb_iram_responder
//
// Self-checking bench for iram_responder: a table of directed vectors with
// hand-computed expectations, directed stack overflow/underflow and
// reset-during-pointer-fetch sequences, and a randomized phase compared against
// a behavioural byte-array model of the RAM and stack pointer.
// ============================================================================
module tb_iram_responder;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_mode;
    logic        req_rw;
    logic [7:0]  req_addr;
    logic [2:0]  req_reg;
    logic [1:0]  req_bank;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic [7:0]  sp_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] model_mem [128];
    int         model_sp;

    typedef struct {
        logic [2:0] mode;
        logic       rw;
        logic [7:0] addr;
        logic [2:0] rg;
        logic [1:0] bank;
        logic [7:0] wd;
        logic [7:0] exp_rd;
        logic       exp_err;
        logic [7:0] exp_sp;
    } vec_t;

    vec_t vecs [21];

    iram_responder #(.DEPTH(128), .SP_RESET(8'h07)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_mode  (req_mode),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_reg   (req_reg),
        .req_bank  (req_bank),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .sp_out    (sp_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 128; i++) model_mem[i] = 8'h00;
        model_sp = 7;
    endtask

    // Behavioural reference: applies one request to the byte array and SP.
    task automatic model_apply(input logic [2:0] mode, input logic rw, input logic [7:0] addr,
                               input logic [2:0] rg, input logic [1:0] bank, input logic [7:0] wd,
                               output logic [7:0] rd, output logic er, output int lat);
        int t;
        rd  = 8'h00;
        er  = 1'b0;
        lat = (mode == 3'd2) ? 3 : 2;
        case (int'(mode))
            0, 1, 2: begin
                if (mode == 3'd0)      t = int'(addr);
                else if (mode == 3'd1) t = int'(bank) * 8 + int'(rg);
                else                   t = int'(model_mem[int'(bank) * 8 + int'(rg[0])]);
                if (t >= 128)  er = 1'b1;
                else if (rw)   rd = model_mem[t];
                else           model_mem[t] = wd;
            end
            3: begin
                if (model_sp == 127) er = 1'b1;
                else begin
                    model_sp++;
                    model_mem[model_sp] = wd;
                end
            end
            4: begin
                if (model_sp == 0) er = 1'b1;
                else begin
                    rd = model_mem[model_sp];
                    model_sp--;
                end
            end
            default: er = 1'b1;
        endcase
    endtask

    // Drives one request into the DUT and collects the response. Starts and
    // ends on a falling edge.
    task automatic run_req(input logic [2:0] mode, input logic rw, input logic [7:0] addr,
                           input logic [2:0] rg, input logic [1:0] bank, input logic [7:0] wd,
                           output logic [7:0] rd, output logic er, output int lat,
                           output logic rdy_resp, output logic valid_after);
        int n;
        n = 0;
        while (!req_ready && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) check("ready_timeout", 32'(req_ready), 32'd1);
        req_mode  = mode;
        req_rw    = rw;
        req_addr  = addr;
        req_reg   = rg;
        req_bank  = bank;
        req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        req_mode  = 3'($urandom);
        req_rw    = 1'($urandom);
        req_addr  = 8'($urandom);
        req_reg   = 3'($urandom);
        req_bank  = 2'($urandom);
        req_wdata = 8'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(negedge clock);
            lat++;
        end
        rd       = rsp_rdata;
        er       = rsp_err;
        rdy_resp = req_ready;
        @(negedge clock);
        valid_after = rsp_valid;
    endtask

    // One request checked against the behavioural model.
    task automatic exec(input string tag, input logic [2:0] mode, input logic rw,
                        input logic [7:0] addr, input logic [2:0] rg, input logic [1:0] bank,
                        input logic [7:0] wd, output logic [7:0] rd, output logic er);
        int         lat, elat;
        logic [7:0] erd;
        logic       eer, rdy_resp, valid_after;
        run_req(mode, rw, addr, rg, bank, wd, rd, er, lat, rdy_resp, valid_after);
        model_apply(mode, rw, addr, rg, bank, wd, erd, eer, elat);
        check($sformatf("%s_lat", tag),   32'(lat), 32'(elat));
        check($sformatf("%s_rdata", tag), 32'(rd),  32'(erd));
        check($sformatf("%s_err", tag),   32'(er),  32'(eer));
        check($sformatf("%s_sp", tag),    32'(sp_out), 32'(model_sp));
        check($sformatf("%s_ready_in_resp", tag), 32'(rdy_resp), 32'd0);
        check($sformatf("%s_strobe_one_cycle", tag), 32'(valid_after), 32'd0);
    endtask

    task automatic wait_clear(output int n, output logic saw_rsp);
        n = 0;
        saw_rsp = 1'b0;
        while (!req_ready && n < 300) begin
            if (rsp_valid || rsp_err || rsp_rdata != 8'h00) saw_rsp = 1'b1;
            @(negedge clock);
            n++;
        end
    endtask

    initial begin
        int         n;
        logic       saw;
        logic [7:0] rd;
        logic       er;
        int         r;
        logic [2:0] m;
        logic [7:0] a;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_mode  = 3'd0;
        req_rw    = 1'b0;
        req_addr  = 8'h00;
        req_reg   = 3'd0;
        req_bank  = 2'd0;
        req_wdata = 8'h00;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_sp", 32'(sp_out), 32'h07);
        check("reset_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        wait_clear(n, saw);
        check("clear_cycles", 32'(n), 32'd128);
        check("clear_outputs_quiet", 32'(saw), 32'd0);
        check("clear_sp", 32'(sp_out), 32'h07);
        model_reset();

        // mode, rw, addr, rg, bank, wdata, exp_rdata, exp_err, exp_sp
        vecs[0]  = '{3'd0, 1'b1, 8'h00, 3'd0, 2'd0, 8'h00, 8'h00, 1'b0, 8'h07};
        vecs[1]  = '{3'd0, 1'b1, 8'h3F, 3'd0, 2'd0, 8'h00, 8'h00, 1'b0, 8'h07};
        vecs[2]  = '{3'd0, 1'b1, 8'h7F, 3'd0, 2'd0, 8'h00, 8'h00, 1'b0, 8'h07};
        vecs[3]  = '{3'd0, 1'b0, 8'h30, 3'd0, 2'd0, 8'h55, 8'h00, 1'b0, 8'h07};
        vecs[4]  = '{3'd0, 1'b1, 8'h30, 3'd0, 2'd0, 8'h00, 8'h55, 1'b0, 8'h07};
        vecs[5]  = '{3'd1, 1'b0, 8'h00, 3'd5, 2'd2, 8'hA1, 8'h00, 1'b0, 8'h07};
        vecs[6]  = '{3'd0, 1'b1, 8'h15, 3'd0, 2'd0, 8'h00, 8'hA1, 1'b0, 8'h07};
        vecs[7]  = '{3'd1, 1'b0, 8'h00, 3'd0, 2'd1, 8'h40, 8'h00, 1'b0, 8'h07};
        vecs[8]  = '{3'd0, 1'b0, 8'h40, 3'd0, 2'd0, 8'h9C, 8'h00, 1'b0, 8'h07};
        vecs[9]  = '{3'd2, 1'b1, 8'h00, 3'd0, 2'd1, 8'h00, 8'h9C, 1'b0, 8'h07};
        vecs[10] = '{3'd3, 1'b0, 8'h00, 3'd0, 2'd0, 8'h11, 8'h00, 1'b0, 8'h08};
        vecs[11] = '{3'd3, 1'b0, 8'h00, 3'd0, 2'd0, 8'h22, 8'h00, 1'b0, 8'h09};
        vecs[12] = '{3'd0, 1'b1, 8'h08, 3'd0, 2'd0, 8'h00, 8'h11, 1'b0, 8'h09};
        vecs[13] = '{3'd4, 1'b1, 8'h00, 3'd0, 2'd0, 8'h00, 8'h22, 1'b0, 8'h08};
        vecs[14] = '{3'd0, 1'b1, 8'h90, 3'd0, 2'd0, 8'h00, 8'h00, 1'b1, 8'h08};
        vecs[15] = '{3'd1, 1'b0, 8'h00, 3'd1, 2'd3, 8'hC0, 8'h00, 1'b0, 8'h08};
        vecs[16] = '{3'd2, 1'b0, 8'h00, 3'd1, 2'd3, 8'h77, 8'h00, 1'b1, 8'h08};
        vecs[17] = '{3'd0, 1'b1, 8'h40, 3'd0, 2'd0, 8'h00, 8'h9C, 1'b0, 8'h08};
        vecs[18] = '{3'd6, 1'b1, 8'h00, 3'd0, 2'd0, 8'h00, 8'h00, 1'b1, 8'h08};
        vecs[19] = '{3'd5, 1'b0, 8'h00, 3'd0, 2'd0, 8'hEE, 8'h00, 1'b1, 8'h08};
        vecs[20] = '{3'd0, 1'b1, 8'h19, 3'd0, 2'd0, 8'h00, 8'hC0, 1'b0, 8'h08};

        for (int i = 0; i < 21; i++) begin
            exec($sformatf("vec%0d", i), vecs[i].mode, vecs[i].rw, vecs[i].addr,
                 vecs[i].rg, vecs[i].bank, vecs[i].wd, rd, er);
            check($sformatf("vec%0d_tbl_rdata", i), 32'(rd), 32'(vecs[i].exp_rd));
            check($sformatf("vec%0d_tbl_err", i),   32'(er), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_tbl_sp", i),    32'(sp_out), 32'(vecs[i].exp_sp));
        end

        // Fill the stack to the top, then one push too many.
        while (model_sp < 127) exec("push_fill", 3'd3, 1'b0, 8'h00, 3'd0, 2'd0, 8'($urandom), rd, er);
        exec("push_ovf", 3'd3, 1'b0, 8'h00, 3'd0, 2'd0, 8'hAB, rd, er);
        check("push_ovf_flag", 32'(er), 32'd1);
        check("push_ovf_sp", 32'(sp_out), 32'h7F);
        check("push_ovf_no_write", 32'(dut.mem_q[127]), 32'(model_mem[127]));

        // Drain it to the bottom, then one pop too many.
        while (model_sp > 0) exec("pop_drain", 3'd4, 1'b1, 8'h00, 3'd0, 2'd0, 8'h00, rd, er);
        exec("pop_unf", 3'd4, 1'b1, 8'h00, 3'd0, 2'd0, 8'h00, rd, er);
        check("pop_unf_flag", 32'(er), 32'd1);
        check("pop_unf_rdata", 32'(rd), 32'd0);
        check("pop_unf_sp", 32'(sp_out), 32'h00);

        // Randomized requests against the model.
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    m = 3'd0;
                2, 3:    m = 3'd1;
                4:       m = 3'd2;
                5, 6:    m = 3'd3;
                7, 8:    m = 3'd4;
                default: m = 3'($urandom_range(5, 7));
            endcase
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 127));
            exec($sformatf("rnd%0d", i), m, 1'($urandom), a, 3'($urandom), 2'($urandom),
                 8'($urandom), rd, er);
        end

        // Reset while a RIDIR request sits in PTR.
        exec("pre_rst_wr", 3'd0, 1'b0, 8'h30, 3'd0, 2'd0, 8'h55, rd, er);
        exec("pre_rst_rd", 3'd0, 1'b1, 8'h30, 3'd0, 2'd0, 8'h00, rd, er);
        check("pre_rst_0x30", 32'(rd), 32'h55);
        req_mode  = 3'd2;
        req_rw    = 1'b1;
        req_reg   = 3'd0;
        req_bank  = 2'd0;
        req_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        check("ptr_ready_low", 32'(req_ready), 32'd0);
        check("ptr_no_rsp", 32'(rsp_valid), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        check("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
        check("rst_mid_sp", 32'(sp_out), 32'h07);
        reset = 1'b0;
        wait_clear(n, saw);
        check("reclear_cycles", 32'(n), 32'd128);
        check("reclear_no_rsp", 32'(saw), 32'd0);
        model_reset();
        exec("post_rst_rd", 3'd0, 1'b1, 8'h30, 3'd0, 2'd0, 8'h00, rd, er);
        check("post_rst_0x30", 32'(rd), 32'h00);
        check("post_rst_sp", 32'(sp_out), 32'h07);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
